// File: rtl/seq_div.sv
// seq_div: sequential unsigned divider built on repeated subtraction.
// Ports:
//   clk         - rising-edge clock
//   rst         - synchronous reset, active-high, highest priority
//   start       - request; only looked at in IDLE
//   dividend    - 2*WIDTH-bit unsigned dividend, captured on accept
//   divisor     - WIDTH-bit unsigned divisor, captured on accept
//   busy        - high while subtracting
//   done        - one-cycle pulse when results become valid
//   quotient    - 2*WIDTH-bit result, held until the next completion
//   remainder   - WIDTH-bit result, held until the next completion
//   div_by_zero - set when the last operation had a zero divisor
module seq_div #(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero
);

  localparam int DW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     r_q, r_d;
  logic [DW-1:0]     q_q, q_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic [DW-1:0]     quotient_q, quotient_d;
  logic [WIDTH-1:0]  remainder_q, remainder_d;
  logic              dbz_q, dbz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DW-1:0]     d_ext_s;

  // Divisor widened to the working-register width for compare/subtract.
  assign d_ext_s = {{WIDTH{1'b0}}, d_q};

  // Next-state and datapath update; registered flags follow the next state.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor != {WIDTH{1'b0}}) begin
            r_d     = dividend;
            d_d     = divisor;
            q_d     = {DW{1'b0}};
            state_d = S_SUB;
          end else begin
            // Zero divisor: report saturated quotient without subtracting.
            quotient_d  = {DW{1'b1}};
            remainder_d = {WIDTH{1'b0}};
            dbz_d       = 1'b1;
            state_d     = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SUB: begin
        if (r_q >= d_ext_s) begin
          r_d     = r_q - d_ext_s;
          q_d     = q_q + {{(DW-1){1'b0}}, 1'b1};
          state_d = S_SUB;
        end else begin
          // R < D here, so the remainder always fits in WIDTH bits.
          quotient_d  = q_q;
          remainder_d = r_q[WIDTH-1:0];
          dbz_d       = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Flags are registered so they line up with the state they describe.
    busy_d = (state_d == S_SUB);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      r_q         <= {DW{1'b0}};
      q_q         <= {DW{1'b0}};
      d_q         <= {WIDTH{1'b0}};
      quotient_q  <= {DW{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed self-checking bench for seq_div with WIDTH=3.
module tb_seq_div;

  localparam int WIDTH = 3;

  logic               clk;
  logic               rst;
  logic               start;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] quotient;
  logic [WIDTH-1:0]   remainder;
  logic               div_by_zero;

  int tests;
  int fails;

  seq_div #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one operation starting at a negedge. exp_edges is the number of
  // clock edges after the accepting edge at which done first appears.
  // prev_q is the quotient expected to be held while the op is in flight.
  // disturb pulses start and changes the dividend in the middle of SUB.
  task automatic run_op(input string tag,
                        input logic [5:0] a, input logic [2:0] b,
                        input int exp_q, input int exp_r, input int exp_dbz,
                        input int exp_edges, input int prev_q, input bit disturb);
    int k;
    int busy_cnt;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 6'd0;
    divisor  = 3'd0;
    k        = 0;
    busy_cnt = 0;
    @(negedge clk);
    if (!done) check({tag, "_held_before_done"}, 32'(quotient), 32'(prev_q));
    while (!done && k < 200) begin
      if (busy) busy_cnt++;
      if (disturb && k == 3) begin
        start    = 1'b1;
        dividend = 6'd60;
        divisor  = 3'd3;
      end
      if (disturb && k == 4) begin
        start    = 1'b0;
        dividend = 6'd11;
      end
      @(negedge clk);
      k++;
    end
    check({tag, "_done"},      32'(done),        32'd1);
    check({tag, "_latency"},   32'(k),           32'(exp_edges));
    check({tag, "_busy_cyc"},  32'(busy_cnt),    32'(exp_edges));
    check({tag, "_busy_dn"},   32'(busy),        32'd0);
    check({tag, "_quotient"},  32'(quotient),    32'(exp_q));
    check({tag, "_remainder"}, 32'(remainder),   32'(exp_r));
    check({tag, "_dbz"},       32'(div_by_zero), 32'(exp_dbz));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done),     32'd0);
    check({tag, "_q_hold"},     32'(quotient), 32'(exp_q));
    check({tag, "_r_hold"},     32'(remainder), 32'(exp_r));
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 6'd0;
    divisor  = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy),        32'd0);
    check("rst_done", 32'(done),        32'd0);
    check("rst_quo",  32'(quotient),    32'd0);
    check("rst_rem",  32'(remainder),   32'd0);
    check("rst_dbz",  32'(div_by_zero), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
    end

    // 45/6 = 7 r 3: busy for 8 cycles, done after edge 8.
    run_op("d45_6", 6'd45, 3'd6, 7, 3, 0, 8, 0, 1'b0);
    // 63/1 = 63 r 0.
    run_op("d63_1", 6'd63, 3'd1, 63, 0, 0, 64, 7, 1'b0);
    // Dividend smaller than divisor: one SUB cycle.
    run_op("d5_7", 6'd5, 3'd7, 0, 5, 0, 1, 63, 1'b0);
    run_op("d0_3", 6'd0, 3'd3, 0, 0, 0, 1, 0, 1'b0);
    // Zero divisor: done in the cycle right after acceptance, no busy.
    run_op("d20_0", 6'd20, 3'd0, 63, 0, 1, 0, 0, 1'b0);
    run_op("d20_4", 6'd20, 3'd4, 5, 0, 0, 6, 63, 1'b0);
    // Start pulse and dividend change mid-SUB must be ignored.
    run_op("d30_2x", 6'd30, 3'd2, 15, 0, 0, 16, 5, 1'b1);

    // Abort 30/2 with reset during SUB.
    dividend = 6'd30;
    divisor  = 3'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy),        32'd0);
    check("abort_done", 32'(done),        32'd0);
    check("abort_quo",  32'(quotient),    32'd0);
    check("abort_rem",  32'(remainder),   32'd0);
    check("abort_dbz",  32'(div_by_zero), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    run_op("d9_2", 6'd9, 3'd2, 4, 1, 0, 5, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
